output_uart_tx: RTL and testbench
=================================

# output_uart_tx

Serial transmit stage fed from the processor's output-port write bus. Byte writes to one decoded output address are queued in a small FIFO and shifted out on a single `tx` line as 8N1 UART frames at a parameterised bit period. It sits beside the parallel output port bank, snoops the same `write_en`/`address`/`data_in` bus, and drives a pin-level serial output plus status flags.

## Interface
- `TX_ADDR`, 8'hEF: write address that enqueues a byte.
- `CLK_DIV`, 16: clock cycles per serial bit, ≥2.
- `FIFO_DEPTH`, 4: queued bytes, power of two, ≥2.
- `clk`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low; 0 clears all state immediately.
- `write_en`  in  1  bus write strobe, one byte per high cycle.
- `address`  in  8  bus write address.
- `data_in`  in  8  bus write data.
- `tx`  out  1  serial line; idle high.
- `busy`  out  1  high while a frame is on the line or the FIFO is non-empty.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  bytes queued, not counting the byte in flight.
- `fifo_full`  out  1  `fifo_count == FIFO_DEPTH`.
- `overflow`  out  1  sticky; set when a write is dropped, cleared only by reset.

## Operation
- Push: `write_en && address == TX_ADDR` at an edge. Other addresses are ignored.
- Push while full is dropped and sets `overflow`. Exception: a push and a pop on the same edge while full is accepted, and the count stays at `FIFO_DEPTH`.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE → START when the FIFO is non-empty. This pops the head into the shift register and loads the bit counter with `CLK_DIV-1`.
  - START: `tx=0` for `CLK_DIV` cycles, then → DATA.
  - DATA: 8 bits, LSB first, `CLK_DIV` cycles each. A 3-bit index tracks the bit. After bit 7 → STOP.
  - STOP: `tx=1` for `CLK_DIV` cycles.
  - At the end of STOP: if the FIFO is non-empty, pop and go directly to START with no idle cycle. Otherwise → IDLE.
- Bit timer: a down-counter of width $clog2(CLK_DIV). Reload on terminal count 0.
- `tx` is registered, never combinational.
- `busy = (state != IDLE) || (fifo_count != 0)`.

## Timing
- Reset values: `tx=1`, `busy=0`, `fifo_count=0`, `fifo_full=0`, `overflow=0`, state IDLE, FIFO pointers 0.
- Latency from an accepted push at edge N into an idle block:
  - `fifo_count` becomes 1 after edge N.
  - The pop happens at edge N+1, and `tx` falls after edge N+1.
- Frame length: exactly 10·`CLK_DIV` cycles.
- Back-to-back frames: the next start bit begins on the cycle immediately after the last stop-bit cycle.
- `busy` falls after the final stop-bit edge if no further push arrived.
- Reset asserted mid-frame:
  - `tx` goes to 1 asynchronously.
  - Queued bytes are discarded.
  - After release, the block is in IDLE and waits for a new push.
- Bus writes during reset are ignored.

## Structure
- Shared package/header holds:
  - FSM state encodings (IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3).
  - Default `TX_ADDR`.
  - Frame constants: 8 data bits, 1 stop bit.
- One sub-module, `sync_fifo`:
  - Parameterised width 8 and `FIFO_DEPTH`.
  - Ports: `push`, `pop`, `din`, `dout` (head, valid when non-empty), `count`, `full`, `empty`.
  - Same clock and reset.
  - Simultaneous push and pop are legal at any fill level.
- Top level contains the address decode, overflow flag, bit timer, FSM and shift register.

## Test plan
- `CLK_DIV=4`, write 0xA5 to 0xEF:
  - `tx` low for cycles 1–4.
  - Then 1,0,1,0,0,1,0,1 for 4 cycles each.
  - Then high for 4 cycles.
  - `busy` drops 41 cycles after the write edge.
- Write 0x3C to 0xEE and 0xE0: `fifo_count` stays 0, `tx` stays 1, `busy` stays 0.
- `FIFO_DEPTH=4`, 6 writes (0x01–0x06) to 0xEF on consecutive cycles:
  - 0x01–0x05 are transmitted in order.
  - 0x06 is dropped and `overflow=1` from the 6th edge onward.
  - `fifo_full=1` after the 5th edge.
- Write 0x00 then 0xFF on consecutive cycles: the stop bit of frame 1 is immediately followed by the start bit of frame 2, with no idle gap (20·`CLK_DIV` cycles continuous).
- Pull `reset` low during the DATA bit 3 of 0x55 with 2 bytes queued:
  - `tx=1` immediately, `fifo_count=0`, `busy=0`.
  - After release with no writes, `tx` stays 1 for 50 cycles.
- Full FIFO with a simultaneous push and end-of-stop pop: the push is accepted, `overflow` stays 0, `fifo_count` stays 4.

Source files
------------

// File: rtl/output_uart_tx_pkg.sv
// Shared constants and FSM encoding for the output-port UART transmitter.
package output_uart_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam logic [7:0]  DEFAULT_TX_ADDR = 8'hEF;
  localparam int unsigned DATA_BITS       = 8;
  localparam int unsigned STOP_BITS       = 1;

endpackage

// File: rtl/output_uart_tx_sync_fifo.sv
// Single-clock FIFO with registered count; head word is always visible on dout.
module output_uart_tx_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A pop frees the slot this edge, so a push while full is still accepted.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/output_uart_tx.sv
// Snoops the output-port write bus and serialises bytes written to TX_ADDR as 8N1 frames.
module output_uart_tx
  import output_uart_tx_pkg::*;
#(
  parameter logic [7:0]  TX_ADDR    = DEFAULT_TX_ADDR,
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          write_en,
  input  logic [7:0]                    address,
  input  logic [7:0]                    data_in,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          fifo_full,
  output logic                          overflow
);

  localparam int unsigned TMR_W = $clog2(CLK_DIV);

  tx_state_e        state;
  logic [TMR_W-1:0] timer;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             push_req;
  logic             pop;
  logic             fifo_empty;
  logic [7:0]       fifo_dout;
  logic             timer_done;

  assign push_req   = write_en && (address == TX_ADDR);
  assign timer_done = (timer == '0);
  // Pop when starting from idle or when a stop bit ends with more data waiting.
  assign pop        = !fifo_empty &&
                      ((state == ST_IDLE) || ((state == ST_STOP) && timer_done));
  assign busy       = (state != ST_IDLE) || !fifo_empty;

  output_uart_tx_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_sync_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .pop   (pop),
    .din   (data_in),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      tx       <= 1'b1;
      timer    <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_req && fifo_full && !pop) overflow <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (pop) begin
            state <= ST_START;
            tx    <= 1'b0;
            shreg <= fifo_dout;
            timer <= TMR_W'(CLK_DIV - 1);
          end
        end
        ST_START: begin
          if (timer_done) begin
            state   <= ST_DATA;
            tx      <= shreg[0];
            bit_idx <= '0;
            timer   <= TMR_W'(CLK_DIV - 1);
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end
        ST_DATA: begin
          if (timer_done) begin
            timer <= TMR_W'(CLK_DIV - 1);
            if (bit_idx == 3'(DATA_BITS - 1)) begin
              state <= ST_STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shreg[1];
              shreg   <= {1'b0, shreg[7:1]};
            end
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end
        ST_STOP: begin
          if (timer_done) begin
            if (pop) begin
              state <= ST_START;
              tx    <= 1'b0;
              shreg <= fifo_dout;
              timer <= TMR_W'(CLK_DIV - 1);
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_output_uart_tx.sv
// Randomised and directed bench for output_uart_tx against a timeline-based frame model.
module tb_output_uart_tx;

  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned FRAME   = 10 * CLK_DIV;
  localparam logic [7:0]  ADDR    = 8'hEF;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       write_en = 1'b0;
  logic [7:0] address = 8'h00;
  logic [7:0] data_in = 8'h00;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_count;
  logic       fifo_full;
  logic       overflow;

  always #5 clk = ~clk;

  output_uart_tx #(
    .TX_ADDR    (ADDR),
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .write_en   (write_en),
    .address    (address),
    .data_in    (data_in),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count),
    .fifo_full  (fifo_full),
    .overflow   (overflow)
  );

  int errors = 0;
  int checks = 0;

  // Model: queued bytes plus the start edge of the frame currently on the line.
  logic [7:0] mq[$];
  longint     cyc = 0;
  longint     m_start = 0;
  longint     m_free = 0;
  logic       m_active = 1'b0;
  logic       m_ovf = 1'b0;
  logic [7:0] m_byte = 8'h00;

  function automatic logic m_in_frame();
    return m_active && ((cyc - m_start) < longint'(FRAME));
  endfunction

  function automatic logic m_tx();
    int idx;
    if (!m_in_frame()) return 1'b1;
    idx = int'((cyc - m_start) / CLK_DIV);
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return m_byte[idx-1];
  endfunction

  function automatic logic m_busy();
    return (mq.size() != 0) || m_in_frame();
  endfunction

  function automatic logic [6:0] m_vec();
    return {m_tx(), m_busy(), 3'(mq.size()), (mq.size() == DEPTH), m_ovf};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_active = 1'b0;
    m_ovf    = 1'b0;
    m_free   = 0;
  endtask

  // One clock: drive bus at the falling edge, update the model at the rising edge.
  task automatic drive_cycle(input logic we, input logic [7:0] a, input logic [7:0] d);
    logic pop_now, req;
    write_en = we;
    address  = a;
    data_in  = d;
    @(posedge clk);
    cyc++;
    pop_now = (mq.size() != 0) && (cyc >= m_free);
    req     = we && (a == ADDR);
    if (req && (mq.size() == DEPTH) && !pop_now) m_ovf = 1'b1;
    if (pop_now) begin
      m_byte   = mq.pop_front();
      m_start  = cyc;
      m_free   = cyc + longint'(FRAME);
      m_active = 1'b1;
    end
    if (req && ((mq.size() < DEPTH) || pop_now)) mq.push_back(d);
    @(negedge clk);
    write_en = 1'b0;
  endtask

  task automatic test_reset();
    reset    = 1'b0;
    write_en = 1'b1;
    address  = ADDR;
    data_in  = 8'h77;
    repeat (3) @(negedge clk);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got=%b exp=1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
    checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", fifo_full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    write_en = 1'b0;
    reset    = 1'b1;
    model_reset();
    drive_cycle(1'b0, 8'h00, 8'h00);
    checks++;
    if ({tx, busy, fifo_count, fifo_full, overflow} !== 7'b1000000) begin
      errors++; $display("FAIL reset_release got=%b exp=1000000", {tx, busy, fifo_count, fifo_full, overflow});
    end
  endtask

  task automatic test_basic_a5();
    logic pat [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic exp_tx, exp_busy;
    drive_cycle(1'b1, ADDR, 8'hA5);
    checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL a5_count got=%0d exp=1", fifo_count); end
    for (int c = 1; c <= 44; c++) begin
      drive_cycle(1'b0, 8'h00, 8'h00);
      if (c <= 4) exp_tx = 1'b0;
      else if (c <= 36) exp_tx = pat[(c - 5) / 4];
      else exp_tx = 1'b1;
      exp_busy = (c <= 40);
      checks++;
      if ({tx, busy} !== {exp_tx, exp_busy}) begin
        errors++; $display("FAIL a5_wave c=%0d got tx/busy=%b%b exp=%b%b", c, tx, busy, exp_tx, exp_busy);
      end
      checks++;
      if ({tx, busy, fifo_count, fifo_full, overflow} !== m_vec()) begin
        errors++; $display("FAIL a5_model c=%0d got=%b exp=%b", c, {tx, busy, fifo_count, fifo_full, overflow}, m_vec());
      end
    end
  endtask

  task automatic test_ignored_addr();
    drive_cycle(1'b1, 8'hEE, 8'h3C);
    drive_cycle(1'b1, 8'hE0, 8'h3C);
    for (int c = 0; c < 6; c++) begin
      checks++;
      if ({tx, busy, fifo_count} !== 5'b10000) begin
        errors++; $display("FAIL ignored_addr c=%0d got tx/busy/count=%b%b%0d exp=1 0 0", c, tx, busy, fifo_count);
      end
      drive_cycle(1'b0, 8'h00, 8'h00);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bb;
    logic       exp_tx;
    int         k, idx;
    drive_cycle(1'b1, ADDR, 8'h00);
    drive_cycle(1'b1, ADDR, 8'hFF);
    for (int c = 1; c <= 81; c++) begin
      if (c > 1) drive_cycle(1'b0, 8'h00, 8'h00);
      if (c <= 80) begin
        bb  = (c <= 40) ? 8'h00 : 8'hFF;
        k   = (c - 1) % 40;
        idx = k / 4;
        exp_tx = (idx == 0) ? 1'b0 : (idx == 9) ? 1'b1 : bb[idx-1];
      end else begin
        exp_tx = 1'b1;
      end
      checks++;
      if ({tx, busy} !== {exp_tx, (c <= 80)}) begin
        errors++; $display("FAIL b2b_wave c=%0d got tx/busy=%b%b exp=%b%b", c, tx, busy, exp_tx, (c <= 80));
      end
    end
  endtask

  task automatic test_full_simultaneous();
    int guard;
    for (int i = 0; i < 5; i++) drive_cycle(1'b1, ADDR, 8'(8'h10 + i));
    checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL simul_prefull got=%b exp=1", fifo_full); end
    guard = 0;
    while ((cyc + 1 < m_free) && guard < 200) begin
      drive_cycle(1'b0, 8'h00, 8'h00);
      guard++;
    end
    drive_cycle(1'b1, ADDR, 8'h15);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL simul_ovf got=%b exp=0", overflow); end
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL simul_count got=%0d exp=4", fifo_count); end
    for (int c = 0; c < 2000 && (busy === 1'b1 || m_busy()); c++) begin
      drive_cycle(1'b0, 8'h00, 8'h00);
      checks++;
      if ({tx, busy, fifo_count, fifo_full, overflow} !== m_vec()) begin
        errors++; $display("FAIL simul_drain c=%0d got=%b exp=%b", c, {tx, busy, fifo_count, fifo_full, overflow}, m_vec());
      end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL simul_timeout busy=%b exp=0", busy); end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 6; i++) begin
      drive_cycle(1'b1, ADDR, 8'(i));
      if (i == 5) begin
        checks++;
        if ({fifo_full, overflow} !== 2'b10) begin
          errors++; $display("FAIL ovf_5th got full/ovf=%b%b exp=10", fifo_full, overflow);
        end
      end
    end
    checks++;
    if ({overflow, fifo_count} !== {1'b1, 3'd4}) begin
      errors++; $display("FAIL ovf_6th got ovf=%b count=%0d exp ovf=1 count=4", overflow, fifo_count);
    end
    for (int c = 0; c < 2000 && (busy === 1'b1 || m_busy()); c++) begin
      drive_cycle(1'b0, 8'h00, 8'h00);
      checks++;
      if ({tx, busy, fifo_count, fifo_full, overflow} !== m_vec()) begin
        errors++; $display("FAIL ovf_drain c=%0d got=%b exp=%b", c, {tx, busy, fifo_count, fifo_full, overflow}, m_vec());
      end
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
  endtask

  task automatic test_reset_mid_frame();
    int guard;
    drive_cycle(1'b1, ADDR, 8'h55);
    drive_cycle(1'b1, ADDR, 8'h11);
    drive_cycle(1'b1, ADDR, 8'h22);
    guard = 0;
    while ((cyc - m_start) != 17 && guard < 100) begin
      drive_cycle(1'b0, 8'h00, 8'h00);
      guard++;
    end
    checks++;
    if ({tx, fifo_count} !== {1'b0, 3'd2}) begin
      errors++; $display("FAIL mid_pre got tx=%b count=%0d exp tx=0 count=2", tx, fifo_count);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({tx, fifo_count, busy} !== {1'b1, 3'd0, 1'b0}) begin
      errors++; $display("FAIL mid_reset got tx=%b count=%0d busy=%b exp 1 0 0", tx, fifo_count, busy);
    end
    model_reset();
    write_en = 1'b1;
    address  = ADDR;
    data_in  = 8'h99;
    repeat (2) @(negedge clk);
    write_en = 1'b0;
    reset    = 1'b1;
    for (int c = 0; c < 50; c++) begin
      drive_cycle(1'b0, 8'h00, 8'h00);
      checks++;
      if ({tx, busy, fifo_count} !== 5'b10000) begin
        errors++; $display("FAIL mid_after c=%0d got tx/busy/count=%b%b%0d exp=1 0 0", c, tx, busy, fifo_count);
      end
    end
  endtask

  task automatic test_random();
    logic       we;
    logic [7:0] a, d;
    for (int c = 0; c < 1500; c++) begin
      we = ($urandom_range(0, 11) == 0);
      a  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : ADDR;
      d  = 8'($urandom);
      drive_cycle(we, a, d);
      checks++;
      if ({tx, busy, fifo_count, fifo_full, overflow} !== m_vec()) begin
        errors++; $display("FAIL random c=%0d got=%b exp=%b", c, {tx, busy, fifo_count, fifo_full, overflow}, m_vec());
      end
    end
    for (int c = 0; c < 2000 && (busy === 1'b1 || m_busy()); c++) begin
      drive_cycle(1'b0, 8'h00, 8'h00);
      checks++;
      if ({tx, busy, fifo_count, fifo_full, overflow} !== m_vec()) begin
        errors++; $display("FAIL random_drain c=%0d got=%b exp=%b", c, {tx, busy, fifo_count, fifo_full, overflow}, m_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_a5();
    test_ignored_addr();
    test_back_to_back();
    test_full_simultaneous();
    test_overflow();
    test_reset_mid_frame();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
